matrix_decompiler: RTL and testbench
====================================

# matrix_decompiler

Receive-side counterpart of the matrix output path. It takes an incoming MSB-first dibit stream carrying a row-major matrix, reassembles the dibits into elements, and tags each element with its row/column address. Tagged elements are buffered in a small FIFO and presented on a valid/ready interface. The block sits between the network receive path (already synchronised to `inter_refclk`) and the matrix-loading logic.

## Interface
- `MAX_ELEMENT_SIZE`, 8: element width in bits. Must be even.
- `MAX_SIZE_A`, 32: number of rows. Must be ≥ 2.
- `MAX_SIZE_B`, 32: number of columns. Must be ≥ 2.
- `FIFO_DEPTH`, 4: element FIFO depth. Power of two, ≥ 2.

Ports:
- `inter_refclk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `frame_start`  in  1  resynchronise; the next dibit is the first dibit of element (0,0).
- `valid_dibit_in`  in  1  `dibit_in` is valid this cycle. No backpressure.
- `dibit_in`  in  2  payload dibit.
- `data_out_ready`  in  1  consumer accepts the FIFO head.
- `valid_data_out`  out  1  FIFO head is valid.
- `row_addr`  out  $clog2(MAX_SIZE_A)  row of the head element.
- `col_addr`  out  $clog2(MAX_SIZE_B)  column of the head element.
- `matrix_element`  out  MAX_ELEMENT_SIZE  head element.
- `frame_done`  out  1  one-cycle pulse when the last element (A-1,B-1) is assembled.
- `overflow`  out  1  sticky flag: an element was dropped because the FIFO was full.

## Operation
- **Assembly.** A shift register and a dibit counter run from 0 to MAX_ELEMENT_SIZE/2-1.
  - The first dibit lands in bits [MSB:MSB-1].
  - When the counter reaches its terminal count on a valid dibit, the element is complete.
  - The dibit counter wraps to 0.
- **Addressing.** Separate row/col counters; no division.
  - On each completed element, col increments.
  - At B-1, col wraps to 0 and row increments.
  - At (A-1,B-1): `frame_done` pulses, and both counters wrap to (0,0) to accept the next frame back-to-back.
- **Push.** A completed element is pushed as {row, col, element}.
  - If the FIFO is full and no pop occurs that cycle, the element is dropped and `overflow` is set.
  - Address counters still advance on a drop, so frame position is preserved.
- **Pop.** A pop occurs when `valid_data_out && data_out_ready`.
- **`frame_start`.**
  - Clears the dibit counter, the shift register and the row/col counters.
  - Clears `overflow`.
  - Does not flush the FIFO.
- **`frame_start` together with `valid_dibit_in` in the same cycle.** The counters clear, and that dibit is taken as dibit 0 of element (0,0).
- **Idle cycles.** Gaps in `valid_dibit_in` are allowed mid-element. State holds while `valid_dibit_in` is low.

## Timing
- **Reset values.**
  - Outputs: `valid_data_out`=0, `frame_done`=0, `overflow`=0, `row_addr`=0, `col_addr`=0, `matrix_element`=0.
  - Internal: FIFO empty, all counters 0.
- **Latency.** If the last dibit of an element is accepted at edge t with the FIFO empty, `valid_data_out`=1 and the element is on the outputs after edge t. There is no combinational path from `dibit_in` to the outputs.
- **`frame_done` timing.** Asserted in the cycle after the edge that completes (A-1,B-1); high for one cycle.
- **Throughput.** One element per MAX_ELEMENT_SIZE/2 valid dibits. The FIFO sustains one push and one pop per cycle.
- **Push and pop in the same cycle.**
  - If the FIFO is full, the push succeeds with no drop.
  - If the FIFO is empty, the new element appears the cycle after the push (no bypass).
- **Head stability.** The outputs stay stable while `valid_data_out && !data_out_ready`.
- **Reset mid-frame.** A partial element is discarded, the FIFO is emptied, and the next dibit starts element (0,0).
- **`overflow`.** Set on the edge of the drop; holds until `rst` or `frame_start`.

## Structure
- **Package `matrix_pkg`:**
  - Size constants: `MAX_ELEMENT_SIZE`, `MAX_SIZE_A`, `MAX_SIZE_B`, and `DIBITS_PER_ELEMENT` = MAX_ELEMENT_SIZE/2.
  - Packed struct `tagged_element_t` = {row, col, element}.
- **Sub-module `element_fifo`.**
  - Synchronous single-clock FIFO of `tagged_element_t`.
  - Ports: full/empty flags, push, pop.
  - A push while full is allowed only when a pop occurs in the same cycle.
- **Top level.** Assembler, address counters and flag logic.

## Test plan
- **Basic element.** `frame_start`, then dibits 2'b10, 2'b11, 2'b00, 2'b01 with ready=1 → `valid_data_out` pulses with `matrix_element`=8'hB1, row=0, col=0.
- **Full frame.** 4096 dibits streamed with ready=1 → 1024 elements in order. Element 32 is tagged (1,0) and element 1023 is tagged (31,31). `frame_done` pulses exactly once, and a second frame restarts at (0,0).
- **Backpressure and overflow.** ready=0 for 5 elements → the first 4 are retained and the 5th is dropped with `overflow`=1. The next element after draining is tagged col=5.
- **Full FIFO, push with pop.** FIFO full; a push occurs in the same cycle as a pop → no drop and `overflow` stays 0.
- **Resync.** `frame_start` with a valid dibit after 2 dibits of element (3,7) → the partial element is discarded, the new element is tagged (0,0), and `overflow` is cleared.
- **Reset mid-element.** `rst` mid-element with 2 elements queued → all outputs 0 on the next cycle, and subsequent dibits form element (0,0).

Source files
------------

// File: rtl/matrix_decompiler_pkg.sv
// Shared sizes and the tagged-element record for the matrix receive path.
// Latency: n/a (types and constants only). Backpressure: n/a.
package matrix_pkg;
    localparam int MAX_ELEMENT_SIZE   = 8;
    localparam int MAX_SIZE_A         = 32;
    localparam int MAX_SIZE_B         = 32;
    localparam int DIBITS_PER_ELEMENT = MAX_ELEMENT_SIZE / 2;

    localparam int ROW_W  = $clog2(MAX_SIZE_A);
    localparam int COL_W  = $clog2(MAX_SIZE_B);
    localparam int DCNT_W = (DIBITS_PER_ELEMENT > 1) ? $clog2(DIBITS_PER_ELEMENT) : 1;

    typedef struct packed {
        logic [ROW_W-1:0]            row;
        logic [COL_W-1:0]            col;
        logic [MAX_ELEMENT_SIZE-1:0] element;
    } tagged_element_t;
endpackage

// File: rtl/matrix_decompiler_if.sv
// Tagged-element output stream: head element plus its row/column address.
// Latency: n/a (wiring). Backpressure: valid/ready, head held while not ready.
interface matrix_decompiler_if;
    import matrix_pkg::*;

    logic                        valid_data_out;
    logic                        data_out_ready;
    logic [ROW_W-1:0]            row_addr;
    logic [COL_W-1:0]            col_addr;
    logic [MAX_ELEMENT_SIZE-1:0] matrix_element;

    modport master (
        output valid_data_out, row_addr, col_addr, matrix_element,
        input  data_out_ready
    );

    modport slave (
        input  valid_data_out, row_addr, col_addr, matrix_element,
        output data_out_ready
    );
endinterface

// File: rtl/matrix_decompiler_element_fifo.sv
// Single-clock FIFO of tagged elements; head reads as zero while empty.
// Latency: 1 cycle push-to-head. Backpressure: push while full only succeeds alongside a pop.
module element_fifo
    import matrix_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            inter_refclk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  tagged_element_t wr_data,
    output tagged_element_t rd_data,
    output logic            full,
    empty
);
    localparam int AW = $clog2(DEPTH);

    tagged_element_t mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge inter_refclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/matrix_decompiler.sv
// Reassembles MSB-first dibits into row-major matrix elements tagged with (row, col).
// Latency: element on outputs the cycle after its last dibit. Backpressure: none on input; drops + sticky overflow when FIFO full.
module matrix_decompiler
    import matrix_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                inter_refclk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                valid_dibit_in,
    input  logic [1:0]          dibit_in,
    matrix_decompiler_if.master elem_bus,
    output logic                frame_done,
    output logic                overflow
);
    localparam int W = MAX_ELEMENT_SIZE;

    logic [DCNT_W-1:0] dcnt, dcnt_eff;
    logic [W-1:0]      shreg, sh_eff;
    logic [ROW_W-1:0]  row, row_eff;
    logic [COL_W-1:0]  col, col_eff;
    logic              elem_done, last_row, last_col;
    logic              pop, drop, full, empty;
    tagged_element_t   push_data, head;

    // frame_start clears state combinationally so a coincident dibit becomes dibit 0 of (0,0).
    always_comb begin
        dcnt_eff  = frame_start ? '0 : dcnt;
        sh_eff    = frame_start ? '0 : shreg;
        row_eff   = frame_start ? '0 : row;
        col_eff   = frame_start ? '0 : col;
        elem_done = valid_dibit_in && (dcnt_eff == DCNT_W'(DIBITS_PER_ELEMENT - 1));
        last_row  = (row_eff == ROW_W'(MAX_SIZE_A - 1));
        last_col  = (col_eff == COL_W'(MAX_SIZE_B - 1));
        push_data = '{row: row_eff, col: col_eff, element: {sh_eff[W-3:0], dibit_in}};
        pop       = !empty && elem_bus.data_out_ready;
        drop      = elem_done && full && !pop;
    end

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            dcnt       <= '0;
            shreg      <= '0;
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= elem_done && last_row && last_col;
            overflow   <= (overflow && !frame_start) || drop;
            if (valid_dibit_in) begin
                shreg <= {sh_eff[W-3:0], dibit_in};
                dcnt  <= elem_done ? '0 : dcnt_eff + DCNT_W'(1);
            end else begin
                shreg <= sh_eff;
                dcnt  <= dcnt_eff;
            end
            // Addresses advance even on a drop so frame position is preserved.
            if (elem_done) begin
                col <= last_col ? '0 : col_eff + COL_W'(1);
                row <= !last_col ? row_eff : (last_row ? '0 : row_eff + ROW_W'(1));
            end else begin
                col <= col_eff;
                row <= row_eff;
            end
        end
    end

    element_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .inter_refclk (inter_refclk),
        .rst          (rst),
        .push         (elem_done),
        .pop          (pop),
        .wr_data      (push_data),
        .rd_data      (head),
        .full         (full),
        .empty        (empty)
    );

    assign elem_bus.valid_data_out = !empty;
    assign elem_bus.row_addr       = head.row;
    assign elem_bus.col_addr       = head.col;
    assign elem_bus.matrix_element = head.element;
endmodule

// File: tb/tb_matrix_decompiler.sv
// Directed bench for matrix_decompiler: hand-computed elements, tags and flags.
module tb_matrix_decompiler;
    import matrix_pkg::*;

    logic       inter_refclk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       valid_dibit_in = 1'b0;
    logic [1:0] dibit_in = 2'b00;
    logic       frame_done, overflow;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    logic [31:0] got [$];

    matrix_decompiler_if bus ();

    matrix_decompiler #(.FIFO_DEPTH(4)) dut (
        .inter_refclk   (inter_refclk),
        .rst            (rst),
        .frame_start    (frame_start),
        .valid_dibit_in (valid_dibit_in),
        .dibit_in       (dibit_in),
        .elem_bus       (bus.master),
        .frame_done     (frame_done),
        .overflow       (overflow)
    );

    always #5 inter_refclk = ~inter_refclk;

    // Inputs change just after posedge; at negedge they show what the next edge will see.
    always @(negedge inter_refclk) begin
        if (!rst && bus.valid_data_out && bus.data_out_ready)
            got.push_back({14'd0, bus.row_addr, bus.col_addr, bus.matrix_element});
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tag_of(input int r, input int c, input logic [7:0] e);
        logic [4:0] r5, c5;
        r5 = 5'(r);
        c5 = 5'(c);
        return {14'd0, r5, c5, e};
    endfunction

    function automatic logic [31:0] got_at(input int idx);
        return (got.size() > idx) ? got[idx] : 32'hFFFF_FFFF;
    endfunction

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge inter_refclk);
            #1;
        end
    endtask

    task automatic send_dibit(input logic [1:0] d);
        valid_dibit_in = 1'b1;
        dibit_in = d;
        step();
        valid_dibit_in = 1'b0;
    endtask

    task automatic send_elem(input logic [7:0] v);
        for (int k = 3; k >= 0; k--) send_dibit(v[2*k +: 2]);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        int bad;
        logic [7:0] v;
        bus.data_out_ready = 1'b0;

        // Reset state
        step(2);
        chk("rst_valid", 32'(bus.valid_data_out), 0);
        chk("rst_elem", 32'(bus.matrix_element), 0);
        chk("rst_row", 32'(bus.row_addr), 0);
        chk("rst_col", 32'(bus.col_addr), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        step();

        // Basic element: 10 11 00 01 -> B1 at (0,0), visible right after last dibit
        bus.data_out_ready = 1'b1;
        pulse_frame_start();
        send_dibit(2'b10); send_dibit(2'b11); send_dibit(2'b00); send_dibit(2'b01);
        chk("basic_valid", 32'(bus.valid_data_out), 1);
        chk("basic_head", {14'd0, bus.row_addr, bus.col_addr, bus.matrix_element}, tag_of(0, 0, 8'hB1));
        step(2);
        chk("basic_drained", 32'(bus.valid_data_out), 0);
        chk("basic_count", 32'(got.size()), 1);

        // Full frame of 1024 elements, then a back-to-back element
        pulse_frame_start();
        got.delete();
        fd_cnt = 0;
        for (int i = 0; i < 1024; i++) send_elem(8'(i) ^ 8'h5A);
        step(3);
        chk("frame_count", 32'(got.size()), 1024);
        chk("frame_done_pulses", 32'(fd_cnt), 1);
        chk("frame_elem32", got_at(32), tag_of(1, 0, 8'(32) ^ 8'h5A));
        chk("frame_elem1023", got_at(1023), tag_of(31, 31, 8'(1023) ^ 8'h5A));
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (got_at(i) !== tag_of(i / 32, i % 32, 8'(i) ^ 8'h5A)) bad++;
        chk("frame_order_bad", 32'(bad), 0);
        send_elem(8'h77);
        step(2);
        chk("frame2_first", got_at(1024), tag_of(0, 0, 8'h77));

        // Backpressure: 5 elements with ready low, 5th dropped
        pulse_frame_start();
        got.delete();
        bus.data_out_ready = 1'b0;
        send_elem(8'h11); send_elem(8'h22); send_elem(8'h33); send_elem(8'h44); send_elem(8'h55);
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_head", {14'd0, bus.row_addr, bus.col_addr, bus.matrix_element}, tag_of(0, 0, 8'h11));
        bus.data_out_ready = 1'b1;
        step(6);
        chk("bp_kept", 32'(got.size()), 4);
        chk("bp_fourth", got_at(3), tag_of(0, 3, 8'h44));
        send_elem(8'h66);
        step(2);
        chk("bp_next_col5", got_at(4), tag_of(0, 5, 8'h66));
        chk("bp_overflow_sticky", 32'(overflow), 1);

        // Full FIFO: push coincides with pop -> no drop
        pulse_frame_start();
        chk("fs_clears_overflow", 32'(overflow), 0);
        got.delete();
        bus.data_out_ready = 1'b0;
        send_elem(8'hA0); send_elem(8'hA1); send_elem(8'hA2); send_elem(8'hA3);
        send_dibit(2'b10); send_dibit(2'b10); send_dibit(2'b01);
        valid_dibit_in = 1'b1;
        dibit_in = 2'b00;
        bus.data_out_ready = 1'b1;
        step();
        valid_dibit_in = 1'b0;
        bus.data_out_ready = 1'b0;
        chk("pp_overflow", 32'(overflow), 0);
        chk("pp_head", {14'd0, bus.row_addr, bus.col_addr, bus.matrix_element}, tag_of(0, 1, 8'hA1));
        bus.data_out_ready = 1'b1;
        step(6);
        chk("pp_count", 32'(got.size()), 5);
        chk("pp_last", got_at(4), tag_of(0, 4, 8'hA4));

        // Resync mid-element (3,7) with a coincident dibit
        pulse_frame_start();
        got.delete();
        bus.data_out_ready = 1'b0;
        for (int i = 0; i < 103; i++) send_elem(8'(i));
        send_dibit(2'b11); send_dibit(2'b11);
        chk("rs_overflow_before", 32'(overflow), 1);
        frame_start = 1'b1;
        valid_dibit_in = 1'b1;
        dibit_in = 2'b01;
        bus.data_out_ready = 1'b1;
        step();
        frame_start = 1'b0;
        valid_dibit_in = 1'b0;
        chk("rs_overflow_cleared", 32'(overflow), 0);
        send_dibit(2'b10); send_dibit(2'b10); send_dibit(2'b11);
        step(3);
        chk("rs_count", 32'(got.size()), 5);
        chk("rs_old_head", got_at(0), tag_of(0, 0, 8'h00));
        chk("rs_new_elem", got_at(4), tag_of(0, 0, 8'h6B));

        // Reset mid-element with 2 elements queued
        pulse_frame_start();
        got.delete();
        bus.data_out_ready = 1'b0;
        send_elem(8'h12); send_elem(8'h34);
        send_dibit(2'b01); send_dibit(2'b01);
        rst = 1'b1;
        step();
        chk("mr_valid", 32'(bus.valid_data_out), 0);
        chk("mr_elem", 32'(bus.matrix_element), 0);
        chk("mr_row", 32'(bus.row_addr), 0);
        chk("mr_col", 32'(bus.col_addr), 0);
        chk("mr_frame_done", 32'(frame_done), 0);
        rst = 1'b0;
        bus.data_out_ready = 1'b1;
        send_dibit(2'b11); send_dibit(2'b00); send_dibit(2'b11); send_dibit(2'b00);
        chk("mr_latency_valid", 32'(bus.valid_data_out), 1);
        step(2);
        chk("mr_count", 32'(got.size()), 1);
        chk("mr_new_elem", got_at(0), tag_of(0, 0, 8'hCC));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
